// File: rtl/seq_shift_add_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_shift_add_mult_pkg                                           |
// | Purpose : Shared definitions for the iterative shift-add multiplier:       |
// |           control state encodings and the default datapath width.          |
// | Ports   : (package, none)                                                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package seq_shift_add_mult_pkg;

  // Encodings are fixed so that debug views and the execute-stage
  // integration see the same values.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mult_state_e;

  localparam int MULT_WIDTH = 32;

endpackage : seq_shift_add_mult_pkg
`default_nettype wire

// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_shift_add_mult                                               |
// | Purpose : Iterative shift-add multiplier returning the low WIDTH bits of   |
// |           a*b. It has no adder of its own: each BUSY cycle it presents     |
// |           acc and the gated multiplicand to the shared execute-stage       |
// |           adder and takes the sum back in the same cycle.                  |
// | Ports   : clk, reset (async, active-high)                                  |
// |           in_valid/in_ready, a, b        operand handshake                 |
// |           out_valid/out_ready, product   result handshake                  |
// |           busy                           high while iterating              |
// |           add_lop/add_rop -> add_sum     shared adder interface            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH,
  parameter int EARLY_EXIT = 0,
  parameter int CW         = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             busy,
  output logic [WIDTH-1:0] add_lop,
  output logic [WIDTH-1:0] add_rop,
  input  logic [WIDTH-1:0] add_sum
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mult_state_e      state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] mcand_d;
  logic [WIDTH-1:0] mplier_d;
  logic [CW-1:0]    cnt_d;
  logic             in_busy;
  logic             rest_zero;
  logic             last_iter;

  assign mcand_d  = mcand_q << 1;
  assign mplier_d = mplier_q >> 1;
  assign cnt_d    = cnt_q + CW'(1);
  assign in_busy  = (state_q == S_BUSY);

  // Early exit looks at the multiplier as it will be after this cycle's
  // shift: if nothing is left, the current add is the final one.
  assign rest_zero = (mplier_d == '0);
  assign last_iter = (cnt_q == LAST_CNT) || ((EARLY_EXIT != 0) && rest_zero);

  // Adder operands are forced to zero outside BUSY so the shared adder is
  // free for other execute-stage users.
  assign add_lop = in_busy ? acc_q : '0;
  assign add_rop = in_busy ? (mcand_q & {WIDTH{mplier_q[0]}}) : '0;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  // acc is frozen in DONE and cleared by reset, so it serves as the result.
  assign product   = acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q    <= add_sum;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_d;
          if (last_iter) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule : seq_shift_add_mult
`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seq_shift_add_mult                                            |
// | Purpose : Self-checking bench for seq_shift_add_mult. Two instances: a     |
// |           fixed-latency one and an early-exit one, each with a behavioural |
// |           adder. Accepted operand pairs push a*b into a queue; completed   |
// |           products pop and compare.                                        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_seq_shift_add_mult;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // fixed-latency instance
  logic         in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [W-1:0] a0, b0, product0, add_lop0, add_rop0, add_sum0;
  // early-exit instance
  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [W-1:0] a1, b1, product1, add_lop1, add_rop1, add_sum1;

  assign add_sum0 = add_lop0 + add_rop0;
  assign add_sum1 = add_lop1 + add_rop1;

  seq_shift_add_mult #(.WIDTH(W), .EARLY_EXIT(0), .CW(6)) u_dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
    .out_valid(out_valid0), .out_ready(out_ready0), .product(product0),
    .busy(busy0), .add_lop(add_lop0), .add_rop(add_rop0), .add_sum(add_sum0)
  );

  seq_shift_add_mult #(.WIDTH(W), .EARLY_EXIT(1), .CW(6)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .product(product1),
    .busy(busy1), .add_lop(add_lop1), .add_rop(add_rop1), .add_sum(add_sum1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard and idle-adder monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid0 && in_ready0) q0.push_back(a0 * b0);
      if (in_valid1 && in_ready1) q1.push_back(a1 * b1);
      if (out_valid0 && out_ready0) begin
        if (q0.size() == 0) check_val("unexpected_product0", {31'd0, out_valid0}, '0);
        else check_val("product0", product0, q0.pop_front());
      end
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) check_val("unexpected_product1", {31'd0, out_valid1}, '0);
        else check_val("product1", product1, q1.pop_front());
      end
      if (!busy0) begin
        check_val("lop_idle0", add_lop0, '0);
        check_val("rop_idle0", add_rop0, '0);
      end
      if (!busy1) begin
        check_val("lop_idle1", add_lop1, '0);
        check_val("rop_idle1", add_rop1, '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents a/b, waits for acceptance, returns just after the accept edge.
  task automatic start_op0(input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc = 0;
    tick();
    in_valid0 = 1'b1; a0 = a; b0 = b;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready0) acc = 1;
    end
    if (!acc) check_val("accept_timeout0", 32'd0, 32'd1);
    tick();
    in_valid0 = 1'b0;
  endtask

  task automatic start_op1(input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc = 0;
    tick();
    in_valid1 = 1'b1; a1 = a; b1 = b;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready1) acc = 1;
    end
    if (!acc) check_val("accept_timeout1", 32'd0, 32'd1);
    tick();
    in_valid1 = 1'b0;
  endtask

  // Counts rising edges from the accept edge (counted as 1) until out_valid.
  task automatic wait_valid0(output int edges, output bit seen);
    edges = 1; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_valid0) seen = 1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    if (!seen) check_val("valid_timeout0", 32'd0, 32'd1);
  endtask

  // Counts BUSY cycles until out_valid.
  task automatic wait_valid1(output int nbusy, output bit seen);
    nbusy = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_valid1) seen = 1;
      else if (busy1) nbusy++;
    end
    if (!seen) check_val("valid_timeout1", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e;
    bit  s;
    int  idles;

    reset = 1'b1;
    in_valid0 = 0; a0 = '0; b0 = '0; out_ready0 = 1'b1;
    in_valid1 = 0; a1 = '0; b1 = '0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check_val("rst_busy", {31'd0, busy0}, 32'd0);
    check_val("rst_product", product0, 32'd0);
    check_val("rst_add_rop", add_rop0, 32'd0);
    tick();
    reset = 1'b0;

    // 1: basic product, latency and single-cycle valid
    start_op0(32'd3, 32'd5);
    wait_valid0(e, s);
    check_val("t1_latency", e, W + 1);
    check_val("t1_product", product0, 32'd15);
    @(negedge clk);
    check_val("t1_pulse", {31'd0, out_valid0}, 32'd0);
    check_val("t1_idle", {31'd0, in_ready0}, 32'd1);

    // 2: wrap-around cases
    start_op0(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid0(e, s);
    check_val("t2_wrap", product0, 32'h0000_0001);
    start_op0(32'h8000_0000, 32'd2);
    wait_valid0(e, s);
    check_val("t2_overflow", product0, 32'd0);

    // 3: backpressure
    tick();
    out_ready0 = 1'b0;
    start_op0(32'd7, 32'd6);
    wait_valid0(e, s);
    for (int i = 0; i < 10; i++) begin
      check_val("t3_hold_valid", {31'd0, out_valid0}, 32'd1);
      check_val("t3_hold_product", product0, 32'd42);
      check_val("t3_in_ready", {31'd0, in_ready0}, 32'd0);
      @(negedge clk);
    end
    tick();
    out_ready0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("t3_back_idle", {31'd0, in_ready0}, 32'd1);
    check_val("t3_valid_low", {31'd0, out_valid0}, 32'd0);

    // 4: asynchronous reset in the 10th BUSY cycle aborts the operation
    start_op0(32'd123, 32'd456);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check_val("t4_out_valid", {31'd0, out_valid0}, 32'd0);
    check_val("t4_busy", {31'd0, busy0}, 32'd0);
    check_val("t4_in_ready", {31'd0, in_ready0}, 32'd1);
    check_val("t4_product", product0, 32'd0);
    tick();
    reset = 1'b0;
    repeat (W + 5) @(negedge clk);
    start_op0(32'd11, 32'd13);
    wait_valid0(e, s);
    check_val("t4_after", product0, 32'd143);

    // 5: in_valid held high with changing operands; one IDLE cycle per op
    tick();
    in_valid0 = 1'b1; a0 = $urandom; b0 = $urandom;
    idles = 0;
    for (int i = 0; i < 3 * (W + 2); i++) begin
      @(negedge clk);
      if (in_ready0) idles++;
      tick();
      a0 = $urandom; b0 = $urandom;
    end
    in_valid0 = 1'b0;
    check_val("t5_idle_cycles", idles, 32'd3);
    repeat (W + 4) @(negedge clk);
    check_val("t5_drained", q0.size(), 32'd0);

    // 6: early exit
    start_op1(32'd9, 32'd1);
    wait_valid1(e, s);
    check_val("t6_busy_b1", e, 32'd1);
    check_val("t6_prod_9", product1, 32'd9);
    start_op1(32'd77, 32'd0);
    wait_valid1(e, s);
    check_val("t6_busy_b0", e, 32'd1);
    check_val("t6_prod_0", product1, 32'd0);
    start_op1(32'd100, 32'h30);
    wait_valid1(e, s);
    check_val("t6_busy_b30", e, 32'd6);
    start_op1(32'd5, 32'h8000_0000);
    wait_valid1(e, s);
    check_val("t6_busy_msb", e, 32'd32);
    repeat (4) @(negedge clk);
    check_val("t6_drained", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_shift_add_mult
`default_nettype wire
